// File: rtl/blaster_fire_seq.sv
// Arm/charge/fire/dump sequencer for the blaster energy path: debounces the buttons, drives the
// charger enable and dump switch, and gates the current-loop PWM through fire_en.
module blaster_fire_seq #(
  parameter int unsigned DEB_CYC    = 16,
  parameter logic [31:0] CHARGE_TMO = 32'h00FF_FFFF,
  parameter logic [31:0] FIRE_CYC   = 32'd48000,
  parameter logic [31:0] DUMP_CYC   = 32'd96000,
  parameter logic [31:0] BLINK_CYC  = 32'd2400000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       arm_button,
  input  logic       fire_button,
  input  logic       cont,
  input  logic       lt3420_done,
  output logic       lt3420_charge,
  output logic       dump,
  output logic       fire_en,
  output logic       arm_led,
  output logic       cont_led,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHARGE = 3'd1,
    READY  = 3'd2,
    FIRE   = 3'd3,
    DUMP   = 3'd4,
    FAULT  = 3'd5
  } state_t;

  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);

  logic [1:0] raw_btn;
  logic [1:0] db_level;
  logic       arm_db;
  logic       fire_db;
  logic       fire_prev_reg;
  logic       fire_rise;

  assign raw_btn = {fire_button, arm_button};

  // Bit 0 = arm, bit 1 = fire. The level flips after DEB_CYC consecutive differing samples.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
      logic [DW-1:0] cnt_reg;
      logic          level_reg;
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt_reg   <= '0;
          level_reg <= 1'b0;
        end else if (raw_btn[gi] == level_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == DEB_LAST) begin
          cnt_reg   <= '0;
          level_reg <= ~level_reg;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
      assign db_level[gi] = level_reg;
    end
  endgenerate

  assign arm_db    = db_level[0];
  assign fire_db   = db_level[1];
  assign fire_rise = fire_db & ~fire_prev_reg;

  state_t      state_reg, state_next;
  logic [31:0] timer_reg, timer_next;
  logic [31:0] blink_cnt_reg, blink_cnt_next;
  logic        blink_reg, blink_next;
  logic        charge_next, dump_next, fire_en_next, arm_led_next;

  // State register plus registered Moore outputs, computed from the upcoming state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      timer_reg     <= '0;
      blink_cnt_reg <= '0;
      blink_reg     <= 1'b0;
      fire_prev_reg <= 1'b0;
      lt3420_charge <= 1'b0;
      dump          <= 1'b0;
      fire_en       <= 1'b0;
      arm_led       <= 1'b0;
      cont_led      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      timer_reg     <= timer_next;
      blink_cnt_reg <= blink_cnt_next;
      blink_reg     <= blink_next;
      fire_prev_reg <= fire_db;
      lt3420_charge <= charge_next;
      dump          <= dump_next;
      fire_en       <= fire_en_next;
      arm_led       <= arm_led_next;
      cont_led      <= cont;
    end
  end

  // Arm release wins over every other event; a fire press without continuity is dropped.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (arm_db && !fire_db) state_next = CHARGE;
      CHARGE: begin
        if (!arm_db)                              state_next = DUMP;
        else if (lt3420_done)                     state_next = READY;
        else if (timer_reg == CHARGE_TMO - 32'd1) state_next = FAULT;
      end
      READY: begin
        if (!arm_db)                state_next = DUMP;
        else if (fire_rise && cont) state_next = FIRE;
      end
      FIRE: begin
        if (!arm_db)                          state_next = DUMP;
        else if (timer_reg == FIRE_CYC - 32'd1) state_next = DUMP;
      end
      DUMP:  if (timer_reg == DUMP_CYC - 32'd1) state_next = IDLE;
      FAULT: if (!arm_db && timer_reg >= DUMP_CYC - 32'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Timer and blink phase restart on every state entry.
  always_comb begin
    timer_next     = (state_next != state_reg) ? 32'd0 : timer_reg + 32'd1;
    blink_cnt_next = '0;
    blink_next     = 1'b0;
    if (state_next == CHARGE && state_reg == CHARGE) begin
      if (blink_cnt_reg == BLINK_CYC - 32'd1) begin
        blink_next = ~blink_reg;
      end else begin
        blink_cnt_next = blink_cnt_reg + 32'd1;
        blink_next     = blink_reg;
      end
    end
  end

  always_comb begin
    charge_next  = 1'b0;
    dump_next    = 1'b0;
    fire_en_next = 1'b0;
    arm_led_next = 1'b0;
    case (state_next)
      CHARGE: begin
        charge_next  = 1'b1;
        arm_led_next = blink_next;
      end
      READY: begin
        charge_next  = 1'b1;
        arm_led_next = 1'b1;
      end
      FIRE: begin
        fire_en_next = 1'b1;
        arm_led_next = 1'b1;
      end
      DUMP:    dump_next = 1'b1;
      FAULT:   dump_next = 1'b1;
      default: ;
    endcase
  end

  assign state = state_reg;

endmodule

// File: tb/tb_blaster_fire_seq.sv
// Directed bench for blaster_fire_seq with short timing parameters; each step waits a fixed
// number of cycles and checks the hand-derived state and outputs.
module tb_blaster_fire_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       arm_button, fire_button, cont, lt3420_done;
  logic       lt3420_charge, dump, fire_en, arm_led, cont_led;
  logic [2:0] state;

  int vecs = 0;
  int errs = 0;

  blaster_fire_seq #(
    .DEB_CYC(4), .CHARGE_TMO(32'd100), .FIRE_CYC(32'd10),
    .DUMP_CYC(32'd8), .BLINK_CYC(32'd5)
  ) dut (
    .clk(clk), .reset(reset), .arm_button(arm_button), .fire_button(fire_button),
    .cont(cont), .lt3420_done(lt3420_done), .lt3420_charge(lt3420_charge),
    .dump(dump), .fire_en(fire_en), .arm_led(arm_led), .cont_led(cont_led),
    .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // state, charge, dump, fire_en, arm_led packed for compact checks
  task automatic check_out(input string tag, input logic [2:0] st, input logic ch,
                           input logic dp, input logic fe, input logic led);
    check(tag, {25'd0, state, lt3420_charge, dump, fire_en, arm_led},
               {25'd0, st, ch, dp, fe, led});
  endtask

  always @(negedge clk) begin
    assert (!(fire_en && lt3420_charge)) else begin
      errs++;
      $error("FAIL inv_fire_charge observed=1 expected=0");
    end
    assert (!(fire_en && dump)) else begin
      errs++;
      $error("FAIL inv_fire_dump observed=1 expected=0");
    end
  end

  initial begin
    reset = 1'b1; arm_button = 1'b0; fire_button = 1'b0; cont = 1'b1; lt3420_done = 1'b0;
    tick(3);
    check_out("reset_outputs", 3'd0, 0, 0, 0, 0);
    check("reset_cont_led", {31'd0, cont_led}, 32'd0);
    reset = 1'b0;
    tick(1);
    check("cont_led_follow", {31'd0, cont_led}, 32'd1);

    // 3-cycle arm glitch must not arm
    arm_button = 1'b1; tick(3); arm_button = 1'b0; tick(5);
    check_out("glitch_idle", 3'd0, 0, 0, 0, 0);
    arm_button = 1'b1; tick(4);
    check_out("deb_edge4_idle", 3'd0, 0, 0, 0, 0);
    tick(1);
    check_out("deb_edge5_charge", 3'd1, 1, 0, 0, 0);
    $display("debounce: arm held -> CHARGE after 5 edges");

    tick(4); check_out("blink_low", 3'd1, 1, 0, 0, 0);
    tick(1); check_out("blink_high", 3'd1, 1, 0, 0, 1);
    tick(4); check_out("blink_high_end", 3'd1, 1, 0, 0, 1);
    tick(1); check_out("blink_low2", 3'd1, 1, 0, 0, 0);
    tick(10);
    lt3420_done = 1'b1; tick(1); lt3420_done = 1'b0;
    check_out("ready", 3'd2, 1, 0, 0, 1);
    $display("charge: done at +20 -> READY");

    cont = 1'b0; fire_button = 1'b1; tick(10);
    check_out("nocont_ready", 3'd2, 1, 0, 0, 1);
    cont = 1'b1; tick(3);
    check_out("nocont_stale_press", 3'd2, 1, 0, 0, 1);
    $display("no continuity: press ignored, stays READY");
    fire_button = 1'b0; tick(6);

    fire_button = 1'b1; tick(4);
    check_out("fire_deb_ready", 3'd2, 1, 0, 0, 1);
    tick(1); check_out("fire_enter", 3'd3, 0, 0, 1, 1);
    tick(9); check_out("fire_last", 3'd3, 0, 0, 1, 1);
    tick(1); check_out("dump_enter", 3'd4, 0, 1, 0, 0);
    tick(7); check_out("dump_last", 3'd4, 0, 1, 0, 0);
    tick(1); check_out("dump_idle", 3'd0, 0, 0, 0, 0);
    tick(2); check_out("fire_held_blocks", 3'd0, 0, 0, 0, 0);
    $display("normal shot: fire 10 cycles, dump 8 cycles, IDLE");
    fire_button = 1'b0; tick(4);
    check_out("fire_rel_idle", 3'd0, 0, 0, 0, 0);
    tick(1); check_out("rearm_charge", 3'd1, 1, 0, 0, 0);

    tick(99); check_out("tmo_last", 3'd1, 1, 0, 0, 1);
    tick(1);  check_out("fault", 3'd5, 0, 1, 0, 0);
    arm_button = 1'b0; tick(7);
    check_out("fault_hold", 3'd5, 0, 1, 0, 0);
    tick(1); check_out("fault_idle", 3'd0, 0, 0, 0, 0);
    $display("timeout: FAULT after 100 cycles, IDLE 8 cycles after release");

    arm_button = 1'b1; tick(5);
    check_out("abort_charge", 3'd1, 1, 0, 0, 0);
    lt3420_done = 1'b1; tick(1); lt3420_done = 1'b0;
    fire_button = 1'b1; tick(5);
    check_out("abort_fire", 3'd3, 0, 0, 1, 1);
    arm_button = 1'b0; tick(4);
    check_out("abort_fire_c4", 3'd3, 0, 0, 1, 1);
    tick(1); check_out("abort_dump", 3'd4, 0, 1, 0, 0);
    tick(7); check_out("abort_dump_last", 3'd4, 0, 1, 0, 0);
    tick(1); check_out("abort_idle", 3'd0, 0, 0, 0, 0);
    $display("abort: arm release in FIRE -> DUMP 8 cycles");
    fire_button = 1'b0; tick(6);

    arm_button = 1'b1; tick(5);
    check_out("simul_charge", 3'd1, 1, 0, 0, 0);
    tick(99);
    lt3420_done = 1'b1; tick(1); lt3420_done = 1'b0;
    check_out("done_beats_tmo", 3'd2, 1, 0, 0, 1);
    $display("simultaneous done+timeout -> READY");

    fire_button = 1'b1; tick(5);
    check_out("rst_fire", 3'd3, 0, 0, 1, 1);
    tick(2);
    reset = 1'b1; tick(1);
    check_out("rst_midfire", 3'd0, 0, 0, 0, 0);
    check("rst_cont_led", {31'd0, cont_led}, 32'd0);
    reset = 1'b0; arm_button = 1'b0; fire_button = 1'b0; tick(1);
    check_out("post_rst_idle", 3'd0, 0, 0, 0, 0);
    check("post_rst_cont_led", {31'd0, cont_led}, 32'd1);
    $display("reset mid-FIRE: outputs cleared on the reset edge");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
